// File: rtl/seq_detector.sv
// seq_detector: serial bit-pattern detector with registered match pulse and saturating match counter
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (highest priority)
//   clr         synchronous soft clear of history, state and counter
//   in_valid    qualifies in; the bit is accepted on the rising edge when high
//   in          serial data bit, first bit of the pattern arrives first
//   out         one-cycle registered pulse per detected match
//   match_count saturating count of matches since reset/clr
//   armed       high while W bits of history are held
module seq_detector #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   PATTERN = 4'b1011,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);
    localparam int FW = $clog2(W + 1);
    localparam logic [FW-1:0] FULL = FW'(W);
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, ARMED = 2'd2} state_t;
    state_t state, state_n;
    logic [W-1:0] hist, hist_n, shifted;
    logic [FW-1:0] fill, fill_n, fill_inc;
    logic [CNT_W-1:0] cnt_n;
    logic match;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hist        <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
            armed       <= 1'b0;
        end else begin
            state       <= state_n;
            hist        <= hist_n;
            fill        <= fill_n;
            out         <= match;
            match_count <= cnt_n;
            armed       <= state_n == ARMED;
        end
    end
    always_comb begin
        state_n  = state;
        hist_n   = hist;
        fill_n   = fill;
        cnt_n    = match_count;
        match    = 1'b0;
        shifted  = {hist[W-2:0], in};
        fill_inc = (fill == FULL) ? FULL : fill + FW'(1);
        if (clr) begin
            state_n = IDLE;
            hist_n  = '0;
            fill_n  = '0;
            cnt_n   = '0;
        end else if (state != IDLE && state != FILL && state != ARMED) begin
            // illegal encoding: recover to a clean empty state, ignore any bit
            state_n = IDLE;
            hist_n  = '0;
            fill_n  = '0;
        end else if (in_valid) begin
            match   = (shifted == PATTERN) && (fill_inc == FULL);
            hist_n  = shifted;
            fill_n  = fill_inc;
            state_n = (fill_inc == FULL) ? ARMED : FILL;
            cnt_n   = (match && match_count != '1) ? match_count + CNT_W'(1) : match_count;
            // non-overlapping mode throws away the history that formed the match
            if (match && OVERLAP == 0) begin
                state_n = IDLE;
                hist_n  = '0;
                fill_n  = '0;
            end
        end
    end
endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: checks three seq_detector configurations against an arithmetic reference model
module tb_seq_detector;
    logic clk = 1'b0;
    logic rst = 1'b0, clr = 1'b0, in_valid = 1'b0, in_bit = 1'b0;
    logic o0, o1, o2, a0, a1, a2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic got_out[3], got_armed[3];
    logic [7:0] got_cnt[3];
    int vectors = 0, errors = 0;
    int hv[3], n[3], cnt[3];
    logic eo[3];
    int ov[3] = '{1, 0, 0};
    int maxc[3] = '{255, 255, 3};

    always #5 clk = ~clk;

    seq_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) d_ov (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(in_bit),
        .out(o0), .match_count(c0), .armed(a0));
    seq_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) d_no (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(in_bit),
        .out(o1), .match_count(c1), .armed(a1));
    seq_detector #(.W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(2)) d_sat (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in(in_bit),
        .out(o2), .match_count(c2), .armed(a2));

    assign got_out[0] = o0;
    assign got_out[1] = o1;
    assign got_out[2] = o2;
    assign got_armed[0] = a0;
    assign got_armed[1] = a1;
    assign got_armed[2] = a2;
    assign got_cnt[0] = c0;
    assign got_cnt[1] = c1;
    assign got_cnt[2] = {6'b0, c2};

    // reference: last-4-bits value, bits held, match tally; rst/clr empty everything
    task automatic model_step(input logic r, input logic c, input logic v, input logic b);
        for (int k = 0; k < 3; k++) begin
            eo[k] = 1'b0;
            if (r || c) begin
                hv[k] = 0;
                n[k] = 0;
                cnt[k] = 0;
            end else if (v) begin
                hv[k] = ((hv[k] * 2) + int'(b)) % 16;
                n[k] = (n[k] < 4) ? n[k] + 1 : 4;
                if (n[k] == 4 && hv[k] == 11) begin
                    eo[k] = 1'b1;
                    if (cnt[k] < maxc[k]) cnt[k]++;
                    if (ov[k] == 0) begin
                        n[k] = 0;
                        hv[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic v, input logic b);
        rst = r;
        clr = c;
        in_valid = v;
        in_bit = b;
        @(posedge clk);
        model_step(r, c, v, b);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_out[k] !== 1'b0 || got_cnt[k] !== 8'd0 || got_armed[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d] out=%b cnt=%0d armed=%b required 0/0/0", k, got_out[k], got_cnt[k], got_armed[k]);
            end
        end
    endtask

    task automatic test_overlap();
        int seq[7] = '{1, 0, 1, 1, 0, 1, 1};
        int p0 = 0, p1 = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, seq[i][0]);
            p0 += int'(o0);
            p1 += int'(o1);
            if (i == 3) begin
                vectors++;
                if (o0 !== 1'b1 || o1 !== 1'b1 || a1 !== 1'b0) begin
                    errors++;
                    $display("FAIL bit4 out_ov=%b out_no=%b armed_no=%b required 1/1/0", o0, o1, a1);
                end
            end
        end
        vectors++;
        if (p0 != 2 || c0 !== 8'd2) begin
            errors++;
            $display("FAIL overlap pulses=%0d cnt=%0d required 2/2", p0, c0);
        end
        vectors++;
        if (p1 != 1 || c1 !== 8'd1) begin
            errors++;
            $display("FAIL no_overlap pulses=%0d cnt=%0d required 1/1", p1, c1);
        end
    endtask

    task automatic test_gap();
        int p = 0;
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            vectors++;
            if (o0 !== 1'b0) begin
                errors++;
                $display("FAIL gap_out cycle %0d got %b required 0", i, o0);
            end
        end
        step(0, 0, 1, 1);
        p += int'(o0);
        step(0, 0, 1, 1);
        vectors++;
        if (o0 !== 1'b1 || p != 0 || c0 !== 8'd1) begin
            errors++;
            $display("FAIL gap_match out=%b early=%0d cnt=%0d required 1/0/1", o0, p, c0);
        end
    endtask

    task automatic test_reset_mid();
        int p = 0;
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        p += int'(o0);
        step(1, 0, 1, 1);
        p += int'(o0);
        step(0, 0, 1, 1);
        p += int'(o0);
        vectors++;
        if (p != 0 || a0 !== 1'b0 || c0 !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid pulses=%0d armed=%b cnt=%0d required 0/0/0", p, a0, c0);
        end
    endtask

    task automatic test_saturate();
        int pat[4] = '{1, 0, 1, 1};
        int p = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, pat[i % 4][0]);
            p += int'(o2);
            if (i == 11 || i == 19) begin
                vectors++;
                if (c2 !== 2'd3) begin
                    errors++;
                    $display("FAIL sat_cnt at bit %0d got %0d required 3", i + 1, c2);
                end
            end
        end
        vectors++;
        if (p != 5) begin
            errors++;
            $display("FAIL sat_pulses got %0d required 5", p);
        end
    endtask

    task automatic test_clr();
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_out[k] !== 1'b0 || got_cnt[k] !== 8'd0 || got_armed[k] !== 1'b0) begin
                errors++;
                $display("FAIL clr[%0d] out=%b cnt=%0d armed=%b required 0/0/0", k, got_out[k], got_cnt[k], got_armed[k]);
            end
        end
    endtask

    task automatic test_random();
        step(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99) < 2, $urandom_range(99) < 3, $urandom_range(99) < 80,
                 ($urandom_range(99) < 60) ? 1'b1 : 1'b0);
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (got_out[k] !== eo[k] || got_cnt[k] !== 8'(cnt[k]) || got_armed[k] !== (n[k] == 4)) begin
                    errors++;
                    $display("FAIL rnd[%0d] cycle %0d out=%b cnt=%0d armed=%b required %b/%0d/%b",
                             k, i, got_out[k], got_cnt[k], got_armed[k], eo[k], cnt[k], n[k] == 4);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_overlap();
        test_gap();
        test_reset_mid();
        test_saturate();
        test_clr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
